// File: rtl/rr_pipe_arb.sv
// Packet-granular round-robin arbiter feeding one registered valid/ready stage.
// A requester that starts a multi-beat packet owns the stage until its last beat is accepted.
module rr_pipe_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int SW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_vld,
  output logic [N_REQ-1:0]    req_rdy,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  output logic [SW-1:0]       out_src
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [SW-1:0] LAST_IDX = SW'(N_REQ - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   owner_q, owner_d;

  logic            vld_p0_q;
  logic [DW-1:0]   data_p0_q;
  logic            last_p0_q;
  logic [SW-1:0]   src_p0_q;

  logic            stg_rdy;
  logic [SW:0]     scan_sum;
  logic [SW-1:0]   gnt_idx;
  logic            gnt_fnd;
  logic [SW-1:0]   sel;
  logic            sel_vld;
  logic            accept;

  assign stg_rdy = ~vld_p0_q | out_rdy;

  // Rotating priority scan starting at ptr_q; first valid requester wins.
  always_comb begin
    scan_sum = '0;
    gnt_idx  = '0;
    gnt_fnd  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (SW+1)'(k);
      if (scan_sum >= (SW+1)'(N_REQ)) scan_sum = scan_sum - (SW+1)'(N_REQ);
      if (!gnt_fnd && req_vld[scan_sum[SW-1:0]]) begin
        gnt_fnd = 1'b1;
        gnt_idx = scan_sum[SW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sel     = gnt_idx;
    sel_vld = gnt_fnd;
    if (state_q == LOCKED) begin
      sel     = owner_q;
      sel_vld = req_vld[owner_q];
    end
    // No handshake may complete on a reset edge, so nothing is offered.
    if (rst) sel_vld = 1'b0;
    accept  = sel_vld & stg_rdy;
    req_rdy = '0;
    if (sel_vld) req_rdy[sel] = stg_rdy;
    if (accept) begin
      if (req_last[sel]) begin
        state_d = IDLE;
        ptr_d   = (sel == LAST_IDX) ? '0 : sel + SW'(1);
      end else begin
        state_d = LOCKED;
        owner_d = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Stage p0: output register, advances whenever it is empty or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
      last_p0_q <= 1'b0;
      src_p0_q  <= '0;
    end else if (stg_rdy) begin
      vld_p0_q <= accept;
      if (accept) begin
        data_p0_q <= req_data[sel*DW +: DW];
        last_p0_q <= req_last[sel];
        src_p0_q  <= sel;
      end
    end
  end

  assign out_vld  = vld_p0_q;
  assign out_data = data_p0_q;
  assign out_last = last_p0_q;
  assign out_src  = src_p0_q;

endmodule

// File: tb/tb_rr_pipe_arb.sv
// Directed bench for rr_pipe_arb: reset, round robin, packet lock, backpressure,
// owner bubble and reset mid-packet, each with hand-computed expectations.
module tb_rr_pipe_arb;

  localparam int N_REQ = 4;
  localparam int DW    = 16;
  localparam int SW    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic                out_vld;
  logic                out_rdy;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic [SW-1:0]       out_src;

  int n_checks = 0;
  int n_pass   = 0;

  rr_pipe_arb #(.N_REQ(N_REQ), .DW(DW), .SW(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_data (req_data),
    .req_last (req_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_last (out_last),
    .out_src  (out_src)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst     = 1'b1;
    req_vld = '0;
    tick();
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    out_rdy  = 1'b1;
    req_vld  = 4'b1111;
    req_last = 4'b1111;
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = 16'hA000 + 16'(i);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b expected 0", out_vld);
      else n_pass++;
      n_checks++;
      if (req_rdy !== 4'b0000) $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy);
      else n_pass++;
    end
    n_checks++;
    if ({out_data, out_last, out_src} !== '0)
      $display("FAIL reset_out_regs: got data=%h last=%b src=%0d expected all 0", out_data, out_last, out_src);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out_src !== 2'd0 || out_data !== 16'hA000)
      $display("FAIL reset_first_beat: got vld=%b src=%0d data=%h expected 1/0/a000", out_vld, out_src, out_data);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_src;
    logic [3:0]  exp_rdy;
    pulse_reset();
    out_rdy  = 1'b1;
    req_vld  = 4'b1111;
    req_last = 4'b1111;
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = 16'hA000 + 16'(i);
    for (int k = 0; k < 5; k++) begin
      exp_src = 2'(k % 4);
      exp_rdy = 4'b0001 << exp_src;
      #1;
      n_checks++;
      if (req_rdy !== exp_rdy) $display("FAIL rr_rdy[%0d]: got %b expected %b", k, req_rdy, exp_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_src !== exp_src || out_data !== (16'hA000 + 16'(exp_src)) || out_last !== 1'b1)
        $display("FAIL rr_beat[%0d]: got vld=%b src=%0d data=%h last=%b expected 1/%0d/%h/1",
                 k, out_vld, out_src, out_data, out_last, exp_src, 16'hA000 + 16'(exp_src));
      else n_pass++;
    end
  endtask

  task automatic test_packet_lock();
    pulse_reset();
    out_rdy  = 1'b1;
    req_vld  = 4'b0110;
    req_data = '0;
    req_data[2*DW +: DW] = 16'hC200;
    for (int b = 0; b < 3; b++) begin
      req_last = (b == 2) ? 4'b0110 : 4'b0100;
      req_data[1*DW +: DW] = 16'hB100 + 16'(b);
      #1;
      n_checks++;
      if (req_rdy !== 4'b0010) $display("FAIL lock_rdy[%0d]: got %b expected 0010", b, req_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_src !== 2'd1 || out_data !== (16'hB100 + 16'(b)) || out_last !== (b == 2))
        $display("FAIL lock_beat[%0d]: got vld=%b src=%0d data=%h last=%b expected src 1 data %h",
                 b, out_vld, out_src, out_data, out_last, 16'hB100 + 16'(b));
      else n_pass++;
    end
    req_vld  = 4'b0100;
    req_last = 4'b0100;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0100) $display("FAIL lock_release_rdy: got %b expected 0100", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out_src !== 2'd2 || out_data !== 16'hC200)
      $display("FAIL lock_next_src: got vld=%b src=%0d data=%h expected 1/2/c200", out_vld, out_src, out_data);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    out_rdy  = 1'b1;
    req_vld  = 4'b0001;
    req_last = 4'b0001;
    req_data = '0;
    req_data[0 +: DW] = 16'h1234;
    tick();
    req_data[0 +: DW] = 16'h5678;
    out_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (req_rdy !== 4'b0000) $display("FAIL bp_rdy[%0d]: got %b expected 0000", c, req_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_data !== 16'h1234 || out_src !== 2'd0 || out_last !== 1'b1)
        $display("FAIL bp_hold[%0d]: got vld=%b data=%h src=%0d last=%b expected 1/1234/0/1",
                 c, out_vld, out_data, out_src, out_last);
      else n_pass++;
    end
    out_rdy = 1'b1;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0001) $display("FAIL bp_resume_rdy: got %b expected 0001", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== 16'h5678)
      $display("FAIL bp_resume_beat: got vld=%b data=%h expected 1/5678", out_vld, out_data);
    else n_pass++;
  endtask

  task automatic test_owner_bubble();
    pulse_reset();
    out_rdy  = 1'b1;
    req_data = '0;
    req_vld  = 4'b0001;
    req_last = 4'b0001;
    req_data[0 +: DW] = 16'hD000;
    tick();
    req_vld  = 4'b1001;
    req_data[0 +: DW]    = 16'hD001;
    req_data[3*DW +: DW] = 16'hE000;
    #1;
    n_checks++;
    if (req_rdy !== 4'b1000) $display("FAIL bub_start_rdy: got %b expected 1000", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_src !== 2'd3 || out_data !== 16'hE000 || out_last !== 1'b0)
      $display("FAIL bub_first_beat: got src=%0d data=%h last=%b expected 3/e000/0", out_src, out_data, out_last);
    else n_pass++;
    req_vld = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (req_rdy !== 4'b0000) $display("FAIL bub_rdy[%0d]: got %b expected 0000", c, req_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (out_vld !== 1'b0) $display("FAIL bub_out_vld[%0d]: got %b expected 0", c, out_vld);
      else n_pass++;
    end
    req_vld  = 4'b1001;
    req_last = 4'b1001;
    req_data[3*DW +: DW] = 16'hE001;
    #1;
    n_checks++;
    if (req_rdy !== 4'b1000) $display("FAIL bub_resume_rdy: got %b expected 1000", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out_src !== 2'd3 || out_data !== 16'hE001 || out_last !== 1'b1)
      $display("FAIL bub_resume_beat: got vld=%b src=%0d data=%h last=%b expected 1/3/e001/1",
               out_vld, out_src, out_data, out_last);
    else n_pass++;
    req_vld = 4'b0001;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0001) $display("FAIL bub_wrap_rdy: got %b expected 0001", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_src !== 2'd0 || out_data !== 16'hD001)
      $display("FAIL bub_wrap_beat: got src=%0d data=%h expected 0/d001", out_src, out_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    pulse_reset();
    out_rdy  = 1'b1;
    req_data = '0;
    req_vld  = 4'b0010;
    req_last = 4'b0010;
    req_data[1*DW +: DW] = 16'hB0B0;
    tick();
    req_vld  = 4'b0100;
    req_last = 4'b0000;
    req_data[2*DW +: DW] = 16'hF000;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0100) $display("FAIL rmp_start_rdy: got %b expected 0100", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_src !== 2'd2 || out_data !== 16'hF000)
      $display("FAIL rmp_first_beat: got src=%0d data=%h expected 2/f000", out_src, out_data);
    else n_pass++;
    rst      = 1'b1;
    req_vld  = 4'b0101;
    req_last = 4'b0001;
    req_data[0 +: DW]    = 16'h0AAA;
    req_data[2*DW +: DW] = 16'hF001;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0000) $display("FAIL rmp_rst_rdy: got %b expected 0000", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b0) $display("FAIL rmp_rst_vld: got %b expected 0", out_vld);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_rdy !== 4'b0001) $display("FAIL rmp_fresh_rdy: got %b expected 0001", req_rdy);
    else n_pass++;
    tick();
    n_checks++;
    if (out_vld !== 1'b1 || out_src !== 2'd0 || out_data !== 16'h0AAA)
      $display("FAIL rmp_fresh_beat: got vld=%b src=%0d data=%h expected 1/0/0aaa", out_vld, out_src, out_data);
    else n_pass++;
  endtask

  initial begin
    rst      = 1'b1;
    out_rdy  = 1'b1;
    req_vld  = '0;
    req_last = '0;
    req_data = '0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_owner_bubble();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
